mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and takes rs/rt read data as operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the 64-bit result in architectural HI/LO registers. HI/LO feed the writeback mux for MFHI/MFLO, and MTHI/MTLO write them directly. Control stalls the PC while Busy is high.

---
 rtl/mult_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Multiply is shift-add and divide is restoring, one bit per cycle over
// DATA_WIDTH cycles, followed by a sign-fix cycle that writes HI/LO.
// Optional build macro MULT_DIV_FAST_MUL_EN: MULT/MULTU use a combinational
// multiplier and skip the iteration phase; divides are unaffected.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO accepted here
// ITER  | one multiplier/quotient bit per cycle
// FIX   | sign correction, HI/LO write, Done pulse
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset_N,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] Operand_A,
    input  logic [DATA_WIDTH-1:0] Operand_B,
    input  logic                  Hi_Write,
    input  logic                  Lo_Write,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    a_orig_q, a_orig_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic            div0_q, div0_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      mul_sum;
    logic            div_ge;
    logic [W-1:0]    div_sub;
    logic [2*W-1:0]  prod_fix;

    // Next-state, datapath step and HI/LO update for the current state
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        signed_op = ~Op[0];
        a_neg     = signed_op & Operand_A[W-1];
        b_neg     = signed_op & Operand_B[W-1];
        a_mag     = a_neg ? -Operand_A : Operand_A;
        b_mag     = b_neg ? -Operand_B : Operand_B;

        // multiply: add multiplicand into upper half when low bit set, then shift right
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        // divide: trial-subtract divisor from remainder shifted left by one
        div_ge   = acc_q[2*W-1:W-1] >= {1'b0, opnd_q};
        div_sub  = acc_q[2*W-2:W-1] - opnd_q;
        prod_fix = neg_lo_q ? -acc_q : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d     = Op;
                    a_orig_d = Operand_A;
                    cnt_d    = '0;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = Op[1] ? a_neg : (a_neg ^ b_neg);
                    div0_d   = Op[1] & (Operand_B == '0);
                    if (Op[1]) begin
                        opnd_d  = b_mag;
                        acc_d   = {{W{1'b0}}, a_mag};
                        state_d = ST_ITER;
                        busy_d  = 1'b1;
                    end else begin
`ifdef MULT_DIV_FAST_MUL_EN
                        opnd_d  = a_mag;
                        acc_d   = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
                        state_d = ST_FIX;
`else
                        opnd_d  = a_mag;
                        acc_d   = {{W{1'b0}}, b_mag};
                        state_d = ST_ITER;
                        busy_d  = 1'b1;
`endif
                    end
                end else begin
                    if (Hi_Write) hi_d = Write_Data;
                    if (Lo_Write) lo_d = Write_Data;
                end
            end
            ST_ITER: begin
                if (op_q[1]) begin
                    if (div_ge) acc_d = {div_sub, acc_q[W-2:0], 1'b1};
                    else        acc_d = {acc_q[2*W-2:W-1], acc_q[W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end else if (div0_q) begin
                    // divide by zero: all-ones quotient, dividend passed through untouched
                    hi_d = a_orig_q;
                    lo_d = {W{1'b1}};
                end else begin
                    hi_d = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                    lo_d = neg_lo_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts everything
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: arithmetic results, latency, Busy/Done
// timing, MTHI/MTLO, ignored Start/writes while busy, and reset abort.
// Honours MULT_DIV_FAST_MUL_EN for multiply latency expectations.
module tb_mult_div_unit;

    logic        Clock = 1'b0;
    logic        Reset_N;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        Hi_Write;
    logic        Lo_Write;
    logic [31:0] Write_Data;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .Clock      (Clock),
        .Reset_N    (Reset_N),
        .Start      (Start),
        .Op         (Op),
        .Operand_A  (Operand_A),
        .Operand_B  (Operand_B),
        .Hi_Write   (Hi_Write),
        .Lo_Write   (Lo_Write),
        .Write_Data (Write_Data),
        .Busy       (Busy),
        .Done       (Done),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: Busy=%b Done=%b, expected 0 0", Busy, Done);
        end
        checks++;
        if (Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: Hi=%h Lo=%h, expected 0 0", Hi, Lo);
        end
        Reset_N = 1'b1;
        tick();
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int lat;
        int busy_cnt;
        int exp_lat;
        int exp_busy;
        bit seen;
        bit stale_bad;
        logic [31:0] hi0;
        logic [31:0] lo0;
        exp_lat  = 33;
        exp_busy = 33;
`ifdef MULT_DIV_FAST_MUL_EN
        if (!op[1]) begin
            exp_lat  = 1;
            exp_busy = 0;
        end
`endif
        hi0 = Hi;
        lo0 = Lo;
        Op = op; Operand_A = a; Operand_B = b; Start = 1'b1;
        tick();
        Start = 1'b0;
        Operand_A = ~a;
        Operand_B = ~b;
        lat = 0; busy_cnt = 0; seen = 0; stale_bad = 0;
        while (!seen && lat < 100) begin
            if (Busy) busy_cnt++;
            tick();
            lat++;
            if (Done) seen = 1;
            else if (Hi !== hi0 || Lo !== lo0) stale_bad = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: no Done within %0d cycles", name, lat);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (busy_cnt != exp_busy) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (stale_bad) begin
            errors++;
            $display("FAIL %s_hilo_hold: Hi/Lo changed before Done, expected %h/%h held", name, hi0, lo0);
        end
        checks++;
        if (Hi !== exp_hi || Lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_result: Hi=%h Lo=%h, expected Hi=%h Lo=%h", name, Hi, Lo, exp_hi, exp_lo);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: Busy=%b, expected 0", name, Busy);
        end
        tick();
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: Done=%b one cycle later, expected 0", name, Done);
        end
    endtask

    task automatic test_arith();
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin");
        run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_negdividend");
        run_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negdivisor");
        run_op(OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu_small");
        run_op(OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_by_zero");
        run_op(OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_by_zero_neg");
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
    endtask

    task automatic test_ignore_busy();
        int lat;
        bit seen;
        Op = OP_DIVU; Operand_A = 32'd100; Operand_B = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            lat++;
        end
        Op = OP_MULTU; Operand_A = 32'd5; Operand_B = 32'd5; Start = 1'b1;
        Hi_Write = 1'b1; Write_Data = 32'h0000DEAD;
        tick();
        lat++;
        Start = 1'b0; Hi_Write = 1'b0;
        checks++;
        if (Hi === 32'h0000DEAD) begin
            errors++;
            $display("FAIL busy_mthi: Hi=%h while busy, expected no MTHI", Hi);
        end
        seen = 0;
        while (!seen && lat < 100) begin
            tick();
            lat++;
            if (Done) seen = 1;
        end
        checks++;
        if (!seen || lat != 33) begin
            errors++;
            $display("FAIL busy_restart_latency: Done seen=%0d at %0d cycles, expected 33", seen, lat);
        end
        checks++;
        if (Hi !== 32'd2 || Lo !== 32'd14) begin
            errors++;
            $display("FAIL busy_restart_result: Hi=%h Lo=%h, expected 2 e", Hi, Lo);
        end
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || Hi !== 32'd2) begin
            errors++;
            $display("FAIL busy_after: Busy=%b Hi=%h, expected 0 2", Busy, Hi);
        end
    endtask

    task automatic test_abort();
        int dones;
        Op = OP_DIVU; Operand_A = 32'd100; Operand_B = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        Reset_N = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset: Busy=%b Done=%b Hi=%h Lo=%h, expected all 0", Busy, Done, Hi, Lo);
        end
        Reset_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) dones++;
        end
        checks++;
        if (dones != 0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d Hi=%h Lo=%h, expected 0 0 0", dones, Hi, Lo);
        end
    endtask

    task automatic test_mt_write();
        int lat;
        bit seen;
        Hi_Write = 1'b1; Write_Data = 32'h00001234;
        tick();
        Hi_Write = 1'b0;
        checks++;
        if (Hi !== 32'h00001234 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL mthi: Hi=%h Lo=%h, expected 1234 0", Hi, Lo);
        end
        Lo_Write = 1'b1; Write_Data = 32'h00005678;
        tick();
        Lo_Write = 1'b0;
        checks++;
        if (Hi !== 32'h00001234 || Lo !== 32'h00005678) begin
            errors++;
            $display("FAIL mtlo: Hi=%h Lo=%h, expected 1234 5678", Hi, Lo);
        end
        Hi_Write = 1'b1; Lo_Write = 1'b1; Write_Data = 32'h0000ABCD;
        tick();
        Hi_Write = 1'b0; Lo_Write = 1'b0;
        checks++;
        if (Hi !== 32'h0000ABCD || Lo !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL mthi_mtlo: Hi=%h Lo=%h, expected abcd abcd", Hi, Lo);
        end
        Op = OP_DIVU; Operand_A = 32'd7; Operand_B = 32'd2; Start = 1'b1;
        Lo_Write = 1'b1; Write_Data = 32'h00009999;
        tick();
        Start = 1'b0; Lo_Write = 1'b0;
        checks++;
        if (Lo !== 32'h0000ABCD || Busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_mtlo: Lo=%h Busy=%b, expected abcd 1", Lo, Busy);
        end
        lat = 0; seen = 0;
        while (!seen && lat < 100) begin
            tick();
            lat++;
            if (Done) seen = 1;
        end
        checks++;
        if (!seen || Hi !== 32'd1 || Lo !== 32'd3) begin
            errors++;
            $display("FAIL start_beats_mtlo_result: seen=%0d Hi=%h Lo=%h, expected 1 1 3", seen, Hi, Lo);
        end
        tick();
    endtask

    initial begin
        Reset_N = 1'b0; Start = 1'b0; Op = 2'b00;
        Operand_A = '0; Operand_B = '0;
        Hi_Write = 1'b0; Lo_Write = 1'b0; Write_Data = '0;
        test_reset();
        test_arith();
        test_ignore_busy();
        test_abort();
        test_mt_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
